// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: controller state encoding, default round count
// and the H0_0..H0_7 initial hash constants shared with the datapath.
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUNDS,
    ST_FINAL,
    ST_WAIT_NEXT,
    ST_DONE
  } ctrl_state_t;

  localparam logic [31:0] H0_0 = 32'h6a09e667;
  localparam logic [31:0] H0_1 = 32'hbb67ae85;
  localparam logic [31:0] H0_2 = 32'h3c6ef372;
  localparam logic [31:0] H0_3 = 32'ha54ff53a;
  localparam logic [31:0] H0_4 = 32'h510e527f;
  localparam logic [31:0] H0_5 = 32'h9b05688c;
  localparam logic [31:0] H0_6 = 32'h1f83d9ab;
  localparam logic [31:0] H0_7 = 32'h5be0cd19;

  function automatic logic [31:0] h0_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return H0_0;
      3'd1:    return H0_1;
      3'd2:    return H0_2;
      3'd3:    return H0_3;
      3'd4:    return H0_4;
      3'd5:    return H0_5;
      3'd6:    return H0_6;
      default: return H0_7;
    endcase
  endfunction

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: clears synchronously, counts while enabled and wraps
// to zero after the terminal count NUM_ROUNDS-1.
module sha256_round_counter #(
  parameter int NUM_ROUNDS = 64,
  parameter int ROUND_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [ROUND_W-1:0] count,
  output logic               tc
);

  logic [ROUND_W-1:0] count_q, count_d;

  assign tc    = (count_q == ROUND_W'(NUM_ROUNDS - 1));
  assign count = count_q;

  // NOTE: count_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + ROUND_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: block handshake, INIT/ROUNDS/FINAL control
// strobes and round index. Optional abort input under SHA256_ROUND_CTRL_ABORT_EN.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA256_ROUNDS,
  parameter int ROUND_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               block_valid,
  input  logic               block_last,
`ifdef SHA256_ROUND_CTRL_ABORT_EN
  input  logic               abort,
`endif
  output logic               block_ready,
  output logic               init_digest,
  output logic               update_digest,
  output logic               init_round,
  output logic               partial_rounds,
  output logic               first_block,
  output logic [ROUND_W-1:0] round_idx,
  output logic               w_load,
  output logic               busy,
  output logic               digest_valid
);

  ctrl_state_t state_q, state_d;
  logic        first_flag_q, first_flag_d;
  logic        last_flag_q, last_flag_d;
  logic        accept;
  logic        abort_in;
  logic        abort_req;
  logic        rnd_tc;

`ifdef SHA256_ROUND_CTRL_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif
  // Abort only acts on an active sequence; in IDLE it merely blocks acceptance.
  assign abort_req = abort_in && (state_q != ST_IDLE);

  sha256_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort_req),
    .en    (state_q == ST_ROUNDS),
    .count (round_idx),
    .tc    (rnd_tc)
  );

  always_comb begin
    state_d      = state_q;
    first_flag_d = first_flag_q;
    last_flag_d  = last_flag_q;
    accept       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (block_valid && !abort_in) begin
          accept       = 1'b1;
          last_flag_d  = block_last;
          first_flag_d = 1'b1;
          state_d      = ST_INIT;
        end
      end
      ST_INIT:   state_d = ST_ROUNDS;
      ST_ROUNDS: if (rnd_tc) state_d = ST_FINAL;
      ST_FINAL: begin
        if (last_flag_q) begin
          state_d = ST_DONE;
        end else begin
          first_flag_d = 1'b0;
          state_d      = ST_WAIT_NEXT;
        end
      end
      ST_WAIT_NEXT: begin
        if (block_valid) begin
          accept       = 1'b1;
          last_flag_d  = block_last;
          first_flag_d = 1'b0;
          state_d      = ST_INIT;
        end
      end
      ST_DONE: begin
        first_flag_d = 1'b0;
        last_flag_d  = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_req) begin
      accept       = 1'b0;
      first_flag_d = 1'b0;
      last_flag_d  = 1'b0;
      state_d      = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      first_flag_q <= 1'b0;
      last_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_flag_q <= first_flag_d;
      last_flag_q  <= last_flag_d;
    end
  end

  // w_load marks the handshake cycle itself, while the block data is still on the bus.
  always_comb begin
    block_ready    = 1'b0;
    init_digest    = 1'b0;
    update_digest  = 1'b0;
    init_round     = 1'b0;
    partial_rounds = 1'b0;
    first_block    = 1'b0;
    w_load         = accept;
    busy           = (state_q != ST_IDLE);
    digest_valid   = 1'b0;
    case (state_q)
      ST_IDLE:      block_ready = 1'b1;
      ST_INIT: begin
        init_digest = 1'b1;
        init_round  = 1'b1;
        first_block = first_flag_q;
      end
      ST_ROUNDS:    partial_rounds = 1'b1;
      ST_FINAL:     update_digest  = 1'b1;
      ST_WAIT_NEXT: block_ready    = 1'b1;
      ST_DONE:      digest_valid   = 1'b1;
      default:      block_ready    = 1'b0;
    endcase
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequencing controller for the SHA-256 compression datapath (the a–h / H0–H7 update logic).
- Accepts 512-bit message blocks through a valid/ready handshake (data path external).
- Drives init_digest, update_digest, init_round, partial_rounds and first_block, plus a round index for the K ROM and the W schedule.
- Reports digest completion at the end of the final block of a message.

Parameters:
- NUM_ROUNDS, 64, compression rounds per block (reduced values allowed for simulation only).
- ROUND_W, 6, width of round_idx; must satisfy 2^ROUND_W >= NUM_ROUNDS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- block_valid  in  1  a message block is available.
- block_last  in  1  qualifies block_valid: this is the message's final block.
- block_ready  out  1  controller accepts a block this cycle.
- init_digest  out  1  to datapath: load H registers.
- update_digest  out  1  to datapath: H += a..h.
- init_round  out  1  to datapath: load a..h.
- partial_rounds  out  1  to datapath: execute one round.
- first_block  out  1  to datapath: select H0_0..H0_7 initial constants.
- round_idx  out  ROUND_W  current round, 0..NUM_ROUNDS-1 (K ROM address / W schedule index).
- w_load  out  1  pulse: W schedule latches the accepted block.
- busy  out  1  state != IDLE.
- digest_valid  out  1  one-cycle pulse: H0..H7 hold the final digest.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; round_idx=0; first_flag=0; last_flag=0.
  - All outputs 0 except block_ready, which is 1 (decoded from IDLE).
- States: IDLE, INIT, ROUNDS, FINAL, WAIT_NEXT, DONE. Outputs are Moore-decoded from registered state and flags.
- IDLE:
  - block_ready=1.
  - On block_valid: latch last_flag=block_last, set first_flag=1, pulse w_load, go to INIT.
- INIT (1 cycle): init_digest=1, init_round=1, first_block=first_flag, round_idx=0. Go to ROUNDS.
- ROUNDS:
  - partial_rounds=1; round_idx increments each cycle.
  - When round_idx==NUM_ROUNDS-1: round_idx returns to 0 and the state goes to FINAL.
- FINAL (1 cycle): update_digest=1, first_block=0.
  - If last_flag=1, go to DONE.
  - Otherwise clear first_flag and go to WAIT_NEXT.
- WAIT_NEXT:
  - block_ready=1.
  - On block_valid: latch last_flag, pulse w_load, go to INIT with first_flag=0, so the datapath reloads a..h from H_reg.
- DONE (1 cycle): digest_valid=1, then go to IDLE.
- Timing: handshake accepted at cycle N gives INIT at N+1, rounds N+2..N+NUM_ROUNDS+1, FINAL at N+NUM_ROUNDS+2, digest_valid at N+NUM_ROUNDS+3 (N+67 at default).
- block_ready=0 in INIT, ROUNDS, FINAL and DONE. block_valid in those states is ignored and the block is not consumed.
- block_last is sampled only on an accepted handshake.
- Mutual exclusion: exactly one of {init_round, partial_rounds} or update_digest is active per cycle, and never both init_digest and update_digest.
- Reset mid-operation: immediate return to IDLE, no digest_valid. The datapath H registers are not cleared by this block.

Optional Feature:
- Macro: SHA256_ROUND_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in any non-IDLE state: next state IDLE, round_idx=0, flags cleared, digest_valid suppressed, control outputs deasserted from the next cycle.
  - abort in IDLE: ignored; a simultaneous block_valid is not accepted that cycle.
- Undefined: no abort port; a sequence can only be terminated by rst.

Decomposition:
- Shared package sha256_pkg holds:
  - state encoding enum (ctrl_state_t);
  - SHA256_ROUNDS=64;
  - the H0_0..H0_7 initial constants (also used by the datapath).
- One natural sub-module: sha256_round_counter (ROUND_W-bit counter with clear, enable and terminal-count output at NUM_ROUNDS-1).

Test Plan:
- Single block "abc" (padded), block_last=1, controller plus datapath:
  - digest_valid exactly 67 cycles after the handshake;
  - H0..H7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - first_block=1 only during the first INIT;
  - WAIT_NEXT reached after block 1;
  - final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- block_valid held high throughout ROUNDS:
  - block_ready=0 and w_load=0 until FINAL completes;
  - the second block is accepted only in WAIT_NEXT or IDLE.
- Async rst asserted at round 30:
  - all outputs 0 and block_ready=1 immediately, without waiting for a clock edge;
  - no digest_valid;
  - a subsequent block yields the correct digest.
- Control checker over a 3-block run:
  - round_idx sweeps 0..63 exactly once per block;
  - partial_rounds high for exactly 64 cycles per block;
  - init/update signals mutually exclusive every cycle.
- With SHA256_ROUND_CTRL_ABORT_EN, abort at round 10:
  - IDLE on the next cycle, digest_valid never asserted;
  - the next message "abc" produces ba7816bf… correctly.
